// File: rtl/parity_serializer.sv
// ============================================================================
// parity_serializer : serializes a parallel word MSB first and appends an
//                     even-parity bit, using a valid/ready handshake.
// Revision 1.0
// ============================================================================
`default_nettype none

module parity_serializer #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  output logic                  readyOut,
  output logic                  seqOut,
  output logic                  frameStart,
  output logic                  frameEnd,
  output logic                  busy
);

  localparam int                CNT_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_word;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_seq;
  logic                  r_fs;
  logic                  r_fe;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_word_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_cnt_dec;
  logic                  w_seq_nxt;
  logic                  w_fs_nxt;
  logic                  w_fe_nxt;
  logic                  w_busy_nxt;

  assign w_cnt_dec = r_cnt - CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_cnt   <= '0;
      r_seq   <= IDLE_LEVEL;
      r_fs    <= 1'b0;
      r_fe    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_cnt   <= w_cnt_nxt;
      r_seq   <= w_seq_nxt;
      r_fs    <= w_fs_nxt;
      r_fe    <= w_fe_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Outputs are computed one cycle ahead so that the bit shown after an
  // edge is exactly the one the state entered at that edge owns.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    w_seq_nxt   = r_seq;
    w_fs_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
    w_busy_nxt  = r_busy;

    case (r_state)
      S_IDLE, S_PARITY: begin
        if (validIn) begin
          w_state_nxt = S_DATA;
          w_word_nxt  = dataIn;
          w_cnt_nxt   = C_CNT_LAST;
          w_seq_nxt   = dataIn[DATA_WIDTH-1];
          w_fs_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_seq_nxt   = IDLE_LEVEL;
          w_busy_nxt  = 1'b0;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_PARITY;
          w_seq_nxt   = ^r_word;
          w_fe_nxt    = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_dec;
          w_seq_nxt   = r_word[w_cnt_dec];
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_seq_nxt   = IDLE_LEVEL;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign readyOut   = (r_state != S_DATA);
  assign seqOut     = r_seq;
  assign frameStart = r_fs;
  assign frameEnd   = r_fe;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer: an 8-bit instance checked cycle by cycle against a
// frame-queue model, plus a 3-bit instance with a high idle level.
`default_nettype none

module tb_parity_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data8;
  logic       valid8;
  logic       ready8, seq8, fs8, fe8, busy8;
  logic [2:0] data3;
  logic       valid3;
  logic       ready3, seq3, fs3, fe3, busy3;
  logic [4:0] obs8;

  int checks;
  int errors;

  parity_serializer #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b0)) dut8 (
    .clk(clk), .rst(rst), .dataIn(data8), .validIn(valid8),
    .readyOut(ready8), .seqOut(seq8), .frameStart(fs8), .frameEnd(fe8), .busy(busy8)
  );

  parity_serializer #(.DATA_WIDTH(3), .IDLE_LEVEL(1'b1)) dut3 (
    .clk(clk), .rst(rst), .dataIn(data3), .validIn(valid3),
    .readyOut(ready3), .seqOut(seq3), .frameStart(fs3), .frameEnd(fe3), .busy(busy3)
  );

  assign obs8 = {ready8, busy8, fs8, fe8, seq8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a queue of the serial bits still owed; the head is the bit on the line.
  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } fbit_t;

  fbit_t mq[$];
  logic  m_rdy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      m_rdy = (mq.size() <= 1);
      if (mq.size() != 0) void'(mq.pop_front());
      if (valid8 && m_rdy) begin
        for (int i = 7; i >= 0; i--) mq.push_back('{b: data8[i], s: (i == 7), e: 1'b0});
        mq.push_back('{b: 1'($countones(data8) % 2), s: 1'b0, e: 1'b1});
      end
    end
  end

  // Expected {readyOut, busy, frameStart, frameEnd, seqOut} for the 8-bit instance.
  function automatic logic [4:0] model_exp();
    if (mq.size() == 0) return 5'b1_0_0_0_0;
    return {(mq.size() <= 1), 1'b1, mq[0].s, mq[0].e, mq[0].b};
  endfunction

  task automatic test_reset();
    rst = 1'b0; valid8 = 1'b0; data8 = '0; valid3 = 1'b0; data3 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs8 !== 5'b1_0_0_0_0) begin
      errors++; $display("FAIL reset8: got %b expected %b", obs8, 5'b10000);
    end
    checks++;
    if ({ready3, busy3, fs3, fe3, seq3} !== 5'b1_0_0_0_1) begin
      errors++; $display("FAIL reset3: got %b expected %b", {ready3, busy3, fs3, fe3, seq3}, 5'b10001);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs8 !== model_exp()) begin
      errors++; $display("FAIL post_reset_idle: got %b expected %b", obs8, model_exp());
    end
  endtask

  task automatic test_a5();
    logic [8:0] bits;
    int         nb;
    bits = '0; nb = 0;
    @(negedge clk); valid8 = 1'b1; data8 = 8'hA5;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      checks++;
      if (obs8 !== model_exp()) begin
        errors++; $display("FAIL a5_cycle%0d: got %b expected %b", c, obs8, model_exp());
      end
      checks++;
      if ({fs8, fe8} !== {c == 0, c == 8}) begin
        errors++; $display("FAIL a5_flags%0d: got %b expected %b", c, {fs8, fe8}, {c == 0, c == 8});
      end
      if (busy8) begin bits = {bits[7:0], seq8}; nb++; end
      valid8 = 1'b0; data8 = 8'($urandom);
    end
    checks++;
    if (bits !== 9'h14A) begin
      errors++; $display("FAIL a5_bits: got %b expected %b", bits, 9'h14A);
    end
    checks++;
    if (nb !== 9) begin
      errors++; $display("FAIL a5_busy_len: got %0d expected 9", nb);
    end
  endtask

  task automatic test_07_detector();
    logic [8:0] bits;
    logic       det;
    bits = '0;
    @(negedge clk); valid8 = 1'b1; data8 = 8'h07;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (obs8 !== model_exp()) begin
        errors++; $display("FAIL h07_cycle%0d: got %b expected %b", c, obs8, model_exp());
      end
      if (busy8) bits = {bits[7:0], seq8};
      valid8 = 1'b0;
    end
    checks++;
    if (bits !== 9'h00F) begin
      errors++; $display("FAIL h07_bits: got %b expected %b", bits, 9'h00F);
    end
    det = ($countones(bits) % 2 == 0);
    checks++;
    if (det !== 1'b1) begin
      errors++; $display("FAIL h07_even_detector: got %b expected 1", det);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] bits;
    int          nb, nlow;
    bits = '0; nb = 0; nlow = 0;
    @(negedge clk); valid8 = 1'b1; data8 = 8'hFF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (obs8 !== model_exp()) begin
        errors++; $display("FAIL b2b_cycle%0d: got %b expected %b", c, obs8, model_exp());
      end
      if (busy8) begin bits = {bits[16:0], seq8}; nb++; end
      if (!ready8) nlow++;
      if (c == 0) data8 = 8'h01;
      if (c == 9) valid8 = 1'b0;
    end
    checks++;
    if (bits !== {8'hFF, 1'b0, 8'h01, 1'b1} || nb !== 18) begin
      errors++; $display("FAIL b2b_stream: got %b (%0d bits) expected %b (18 bits)", bits, nb, {8'hFF, 1'b0, 8'h01, 1'b1});
    end
    checks++;
    if (nlow !== 16) begin
      errors++; $display("FAIL b2b_ready_low: got %0d cycles expected 16", nlow);
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] bits;
    bits = '0;
    @(negedge clk); valid8 = 1'b1; data8 = 8'hC3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      valid8 = 1'b0;
      checks++;
      if (obs8 !== model_exp()) begin
        errors++; $display("FAIL c3_cycle%0d: got %b expected %b", c, obs8, model_exp());
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs8 !== 5'b1_0_0_0_0) begin
      errors++; $display("FAIL async_reset: got %b expected %b", obs8, 5'b10000);
    end
    @(negedge clk);
    rst = 1'b1; valid8 = 1'b1; data8 = 8'h80;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      valid8 = 1'b0;
      checks++;
      if (obs8 !== model_exp()) begin
        errors++; $display("FAIL h80_cycle%0d: got %b expected %b", c, obs8, model_exp());
      end
      if (busy8) bits = {bits[7:0], seq8};
    end
    checks++;
    if (bits !== 9'h101) begin
      errors++; $display("FAIL h80_bits: got %b expected %b", bits, 9'h101);
    end
  endtask

  task automatic test_ignore_valid();
    logic [7:0] w;
    logic [8:0] bits;
    int         nb;
    w = 8'($urandom); bits = '0; nb = 0;
    @(negedge clk); valid8 = 1'b1; data8 = w;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      checks++;
      if (obs8 !== model_exp()) begin
        errors++; $display("FAIL ignore_cycle%0d: got %b expected %b", c, obs8, model_exp());
      end
      if (busy8) begin bits = {bits[7:0], seq8}; nb++; end
      if (c < 8) begin valid8 = 1'($urandom); data8 = 8'($urandom); end
      else valid8 = 1'b0;
    end
    checks++;
    if (bits !== {w, 1'($countones(w) % 2)} || nb !== 9) begin
      errors++; $display("FAIL ignore_frame: got %b (%0d bits) expected %b (9 bits)", bits, nb, {w, 1'($countones(w) % 2)});
    end
  endtask

  task automatic test_random();
    logic was_ready;
    was_ready = ready8;
    valid8 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if (obs8 !== model_exp()) begin
        errors++; $display("FAIL random_cycle%0d: got %b expected %b", c, obs8, model_exp());
      end
      if (valid8 && was_ready) valid8 = 1'b0;
      if (!valid8 && $urandom_range(0, 2) != 0) begin
        valid8 = 1'b1; data8 = 8'($urandom);
      end
      was_ready = ready8;
    end
    valid8 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (obs8 !== model_exp()) begin
        errors++; $display("FAIL random_drain%0d: got %b expected %b", c, obs8, model_exp());
      end
    end
  endtask

  task automatic test_w3();
    logic [3:0] bits;
    bits = '0;
    @(negedge clk); valid3 = 1'b1; data3 = 3'b110;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      valid3 = 1'b0; data3 = 3'($urandom);
      checks++;
      if ({ready3, busy3, fs3, fe3} !== {c >= 3, c < 4, c == 0, c == 3}) begin
        errors++; $display("FAIL w3_ctrl%0d: got %b expected %b", c, {ready3, busy3, fs3, fe3}, {c >= 3, c < 4, c == 0, c == 3});
      end
      if (busy3) bits = {bits[2:0], seq3};
      else begin
        checks++;
        if (seq3 !== 1'b1) begin
          errors++; $display("FAIL w3_idle_level%0d: got %b expected 1", c, seq3);
        end
      end
    end
    checks++;
    if (bits !== 4'b1100) begin
      errors++; $display("FAIL w3_bits: got %b expected %b", bits, 4'b1100);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_a5();
    test_07_detector();
    test_back_to_back();
    test_reset_midframe();
    test_ignore_valid();
    test_random();
    test_w3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/parity_serializer.md
PARITY_SERIALIZER -- requirements
Module: parity_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame; legal range 2..32.
REQ-002 Parameter IDLE_LEVEL, default 0, value driven on seqOut when no frame is in flight; legal values 0 and 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 dataIn  input  DATA_WIDTH  parallel word to serialize; sampled only on an accepted handshake.
REQ-006 validIn  input  1  upstream has a word on dataIn.
REQ-007 readyOut  output  1  block can accept a word this cycle.
REQ-008 seqOut  output  1  serial bit stream for the downstream serial parity checker.
REQ-009 frameStart  output  1  high during the first payload bit of a frame.
REQ-010 frameEnd  output  1  high during the parity bit of a frame.
REQ-011 busy  output  1  high while a frame is being shifted (payload or parity bit).

Function
REQ-012 Handshake: a word is accepted at a rising edge where validIn=1 and readyOut=1; no other edge captures dataIn.
REQ-013 The state machine has three states: IDLE, DATA and PARITY.
REQ-014 readyOut is 1 in IDLE and PARITY and 0 in DATA; readyOut is a function of state only and does not depend on validIn.
REQ-015 On acceptance, the block latches the word, sets the bit counter to DATA_WIDTH-1 and enters DATA.
REQ-016 In DATA, seqOut carries latched bits MSB first, one bit per cycle, for exactly DATA_WIDTH cycles; it then enters PARITY.
REQ-017 In PARITY, seqOut equals the XOR reduction of the latched word for exactly one cycle, so every frame of DATA_WIDTH+1 bits contains an even number of ones.
REQ-018 Latency: for a word accepted at edge k, the MSB is on seqOut from edge k until edge k+1, and the parity bit is on seqOut from edge k+DATA_WIDTH until edge k+DATA_WIDTH+1.
REQ-019 frameStart is 1 only while the MSB is on seqOut.
REQ-020 frameEnd is 1 only while the parity bit is on seqOut.
REQ-021 busy is 1 in DATA and PARITY and 0 in IDLE.
REQ-022 seqOut, frameStart, frameEnd and busy are registered outputs, free of combinational paths from inputs.
REQ-023 Back-to-back: an acceptance during PARITY moves directly to DATA with a zero-cycle gap; the next frame's MSB immediately follows the parity bit.
REQ-024 End of frame: if PARITY ends without an acceptance, the block returns to IDLE and seqOut=IDLE_LEVEL.
REQ-025 validIn during DATA is ignored; the upstream must hold dataIn and validIn until accepted.
REQ-026 Changes on dataIn after acceptance do not affect the frame in flight.
REQ-027 The bit counter is $clog2(DATA_WIDTH) bits wide.
REQ-028 The bit counter never wraps within a frame; DATA exits when the counter reaches 0.

Reset
REQ-029 When rst=0, the block immediately enters IDLE with readyOut=1, seqOut=IDLE_LEVEL, frameStart=0, frameEnd=0, busy=0, bit counter=0 and the latched word cleared.
REQ-030 Reset asserted mid-frame aborts the frame; the partial word is discarded and is not resumed after rst returns to 1.
REQ-031 The first acceptance is possible at the first rising edge after rst deasserts.

Verification
REQ-032 The bench shall cover: DATA_WIDTH=8, accept 8'hA5 -> seqOut 1,0,1,0,0,1,0,1 then parity 0; frameStart on bit 1 only; frameEnd on bit 9 only; busy for 9 cycles; then IDLE.
REQ-033 The bench shall cover: accept 8'h07 -> payload 0,0,0,0,0,1,1,1 then parity 1; the downstream even-parity detector reads 1 after the parity bit.
REQ-034 The bench shall cover: validIn held high with words 8'hFF then 8'h01 -> 18 consecutive frame bits with no gap; parity bits 0 then 1; readyOut low during both DATA phases.
REQ-035 The bench shall cover: rst pulsed low after the 4th payload bit of 8'hC3 -> outputs return to reset values asynchronously; next accepted word 8'h80 gives 1,0,0,0,0,0,0,0 then parity 1.
REQ-036 The bench shall cover: validIn toggled and dataIn changed while in DATA -> the in-flight frame is unchanged and no extra acceptance occurs.
REQ-037 The bench shall cover: DATA_WIDTH=3 with IDLE_LEVEL=1, accept 3'b110 -> seqOut 1,1,0 then parity 0, then idles at 1.
